demux_1_4_stream: RTL and testbench
===================================

# demux_1_4_stream

Stream demultiplexer with a 1-to-4 valid/ready handshake. It is the counterpart of the 4:1 data multiplexer: it takes one W-bit input stream tagged with a 2-bit channel select and routes each beat to one of four output channels. Each channel has a one-entry output register, so a stalled channel does not block beats going to the other channels. Each channel also keeps a saturating count of delivered beats for debug.

## Interface
- W, default 4: data width. Must be even and ≥ 2, because routing is built from 2-bit slices.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  demux accepts the beat this cycle.
- in_data  in  W  input payload.
- in_sel  in  2  destination channel, 0..3. Part of the payload; must be held stable while in_valid=1 and in_ready=0.
- out_valid  out  4  bit i: channel i register holds a beat.
- out_ready  in  4  bit i: channel i consumer accepts.
- out_data0..out_data3  out  W each  channel register contents.
- cnt0..cnt3  out  8 each  beats delivered on each channel (output handshakes), saturating.

## Operation
- Per channel i, state is: full[i] (drives out_valid[i]), data register d[i] (drives out_dataN), and counter c[i].
- in_ready = !full[in_sel] | out_ready[in_sel]. This path is combinational from in_sel and out_ready. There is no combinational path from in_valid to in_ready.
- Input transfer: in_valid & in_ready. On a transfer, d[in_sel] <= in_data and full[in_sel] <= 1.
- Output transfer on channel i: full[i] & out_ready[i]. It clears full[i], unless an input transfer to channel i happens in the same cycle; then full[i] stays 1 and d[i] takes the new beat. This gives full throughput on one channel.
- Unselected channels keep d and full unchanged.
- While full[i]=1 and out_ready[i]=0, out_data[i] is held stable.
- d[i] is written only on an input transfer. Its contents are don't-care while full[i]=0 but must not change.
- Counter c[i] increments by 1 on each channel-i output transfer and saturates at 255; it does not wrap.
- Beats to the same channel leave in input order. Beats to different channels have no ordering relation.
- out_ready[i] while full[i]=0 has no effect.
- in_valid=0: no state change except output transfers.

## Timing
- Reset values, applied asynchronously during rst: full=0000 (out_valid=0), all out_data=0, all cnt=0. in_ready is therefore 1 after reset.
- Reset is released synchronously to clk by the environment.
- Asserting rst mid-operation discards all held beats and clears the counters immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge k appears on out_valid/out_data of its channel after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle on a channel whose consumer holds out_ready=1. With out_ready low, a channel absorbs 1 beat, then back-pressures only inputs addressed to it.
- Boundary case, channel full with out_ready low: in_ready=0 for that in_sel, and the register and counter are unchanged.
- Boundary case, counter at 255 plus another output transfer: stays at 255.

## Structure
- Package demux_pkg holds:
  - N_CH=4, SEL_W=2, CNT_W=8, CNT_MAX=8'd255.
  - typedef logic [SEL_W-1:0] ch_sel_t.
- Sub-module demux_1_4_width_2 (combinational): 2-bit d, sel[1:0] → y0..y3, with the selected output equal to d and the others 0.
  - Instantiate W/2 times via generate to form the per-channel write data.
  - Write enables are decoded separately from in_sel.
- Top level contains the full flags, data registers, counters, and in_ready logic.

## Test plan
- Reset and basic routing:
  - Assert rst mid-stream → out_valid=0 and cnt*=0 in the same cycle, in_ready=1.
  - After release, send sel=2, data=4'hA with all out_ready=0 → the next cycle out_valid=4'b0100, out_data2=A, in_ready=1 for sel≠2.
- Back-pressure:
  - Channel 1 full with out_ready[1]=0, offer sel=1, data=5 → in_ready=0 and out_data1 is unchanged for 10 cycles.
  - Raise out_ready[1] → the held beat transfers, 5 is accepted the same cycle, and cnt1 increments.
- Full throughput: stream 0,1,2,…,15 to channel 3 with out_ready[3]=1 → in_ready stays 1 and out_data3 shows 0..15 on consecutive cycles, each 1 cycle after acceptance.
- Independence: channel 0 stalled and full; send beats to channels 1–3 → all accepted, channel 0 data unchanged.
- Saturation: 300 output transfers on channel 0 → cnt0=255, with other counters unaffected.
- Randomized routing: random sel, data, and out_ready for 10k cycles; a scoreboard checks per-channel ordering and counter values. Repeat with W=8.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef logic [SEL_W-1:0] ch_sel_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/demux_1_4_width_2.sv
// 2-bit 1:4 demultiplexer slice: the selected output carries d, the others are zero.
module demux_1_4_width_2
  import demux_pkg::*;
(
  input  logic [1:0] d,
  input  ch_sel_t    sel,
  output logic [1:0] y0,
  output logic [1:0] y1,
  output logic [1:0] y2,
  output logic [1:0] y3
);

  // route the slice to the selected output
  always_comb begin
    y0 = 2'b00;
    y1 = 2'b00;
    y2 = 2'b00;
    y3 = 2'b00;
    case (sel)
      2'd0:    y0 = d;
      2'd1:    y1 = d;
      2'd2:    y2 = d;
      2'd3:    y3 = d;
      default: y0 = 2'b00;
    endcase
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry register and a
// saturating delivered-beat counter per output channel.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  ch_sel_t          in_sel,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [N_CH-1:0]             full_q, full_d;
  logic [N_CH-1:0]             wr_en_s, rd_en_s;
  logic [N_CH-1:0][W-1:0]      data_q, data_d, wr_data_s;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  // Per-channel write data is built from 2-bit demux slices.
  for (genvar g = 0; g < W / 2; g++) begin : g_slice
    demux_1_4_width_2 u_slice (
      .d   (in_data[2*g +: 2]),
      .sel (in_sel),
      .y0  (wr_data_s[0][2*g +: 2]),
      .y1  (wr_data_s[1][2*g +: 2]),
      .y2  (wr_data_s[2][2*g +: 2]),
      .y3  (wr_data_s[3][2*g +: 2])
    );
  end

  // A full channel still accepts when its consumer drains it in the same cycle.
  assign in_ready = ~full_q[in_sel] | out_ready[in_sel];
  assign rd_en_s  = full_q & out_ready;

  // decode the write enable of the addressed channel
  always_comb begin
    wr_en_s = 4'b0000;
    if (in_valid && in_ready) begin
      case (in_sel)
        2'd0:    wr_en_s = 4'b0001;
        2'd1:    wr_en_s = 4'b0010;
        2'd2:    wr_en_s = 4'b0100;
        2'd3:    wr_en_s = 4'b1000;
        default: wr_en_s = 4'b0000;
      endcase
    end else begin
      wr_en_s = 4'b0000;
    end
  end

  // next-state for full flags, data registers and counters
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en_s[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = wr_data_s[i];
      end else if (rd_en_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
      if (rd_en_s[i]) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = full_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: directed scenarios plus randomized traffic on
// W=4 and W=8 instances driven in lockstep against a queue-based model.
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data8;
  logic [3:0] in_data4;
  logic [3:0] out_ready;

  logic            in_ready4, in_ready8;
  logic [3:0]      ov4, ov8;
  logic [3:0][3:0] od4;
  logic [3:0][7:0] od8;
  logic [3:0][7:0] c4, c8;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each channel is a queue of at most one pending beat.
  logic [7:0] chq [4][$];
  logic [7:0] mlast [4];
  int         mcnt [4];
  bit         last_acc = 1'b0;

  assign in_data4 = in_data8[3:0];

  always #5 clk = ~clk;

  demux_1_4_stream #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data4), .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready),
    .out_data0(od4[0]), .out_data1(od4[1]), .out_data2(od4[2]), .out_data3(od4[3]),
    .cnt0(c4[0]), .cnt1(c4[1]), .cnt2(c4[2]), .cnt3(c4[3])
  );

  demux_1_4_stream #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data8), .in_sel(in_sel), .out_valid(ov8), .out_ready(out_ready),
    .out_data0(od8[0]), .out_data1(od8[1]), .out_data2(od8[2]), .out_data3(od8[3]),
    .cnt0(c8[0]), .cnt1(c8[1]), .cnt2(c8[2]), .cnt3(c8[3])
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      chq[i].delete();
      mlast[i] = 8'h00;
      mcnt[i]  = 0;
    end
  endtask

  // One clock: decide acceptance from the model, advance past the edge, update the model.
  task automatic tick();
    bit acc;
    int s;
    s   = int'(in_sel);
    acc = in_valid && (chq[s].size() == 0 || out_ready[s]);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (out_ready[i] && chq[i].size() != 0) begin
        void'(chq[i].pop_front());
        if (mcnt[i] < 255) mcnt[i]++;
      end
    end
    if (acc) begin
      chq[s].push_back(in_data8);
      mlast[s] = in_data8;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data8 = 8'h00; out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    n_tests++;
    if (ov4 !== 4'b0000 || c4 !== 32'h0 || in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: ov=%b cnt=%h rdy=%b expected 0000/0/1", ov4, c4, in_ready4);
    end
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      in_data8 = 8'(k + 1);
      tick();
    end
    in_sel = 2'd2; in_data8 = 8'h07; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    exp_v = 4'b0000;
    for (int i = 0; i < 4; i++) exp_v[i] = (chq[i].size() != 0);
    n_tests++;
    if (ov4 !== exp_v || c4[0] !== mcnt[0][7:0]) begin
      n_fail++;
      $display("FAIL reset_prestate: ov=%b cnt0=%0d expected %b/%0d", ov4, c4[0], exp_v, mcnt[0]);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (ov4 !== 4'b0000 || ov8 !== 4'b0000 || c4 !== 32'h0 || c8 !== 32'h0 || in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: ov=%b/%b cnt=%h/%h rdy=%b expected 0/0/0/0/1", ov4, ov8, c4, c8, in_ready4);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_routing();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd2; in_data8 = 8'h0A;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (ov4 !== 4'b0100 || od4[2] !== 4'hA || od8[2] !== 8'h0A) begin
      n_fail++;
      $display("FAIL route_sel2: ov=%b d2=%h/%h expected 0100/a/0a", ov4, od4[2], od8[2]);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      n_tests++;
      if (in_ready4 !== (s != 2)) begin
        n_fail++;
        $display("FAIL route_ready sel=%0d: got %b expected %b", s, in_ready4, (s != 2));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data8 = 8'h03;
    tick();
    in_data8 = 8'h05;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if (in_ready4 !== 1'b0 || od4[1] !== 4'h3 || c4[1] !== 8'd0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d: rdy=%b d1=%h cnt1=%0d expected 0/3/0", k, in_ready4, od4[1], c4[1]);
      end
      tick();
    end
    out_ready = 4'b0010;
    #1;
    n_tests++;
    if (in_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready4);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (ov4[1] !== 1'b1 || od4[1] !== 4'h5 || c4[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_release: v1=%b d1=%h cnt1=%0d expected 1/5/1", ov4[1], od4[1], c4[1]);
    end
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_throughput();
    out_ready = 4'b1000; in_valid = 1'b1; in_sel = 2'd3;
    for (int k = 0; k < 16; k++) begin
      in_data8 = 8'(k);
      #1;
      n_tests++;
      if (in_ready4 !== 1'b1) begin
        n_fail++;
        $display("FAIL tput_ready k=%0d: got %b expected 1", k, in_ready4);
      end
      tick();
      n_tests++;
      if (ov4[3] !== 1'b1 || od4[3] !== 4'(k)) begin
        n_fail++;
        $display("FAIL tput_data k=%0d: v3=%b d3=%h expected 1/%h", k, ov4[3], od4[3], 4'(k));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_independence();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data8 = 8'h06;
    tick();
    out_ready = 4'b1110;
    for (int k = 1; k < 10; k++) begin
      in_sel = 2'(1 + (k % 3));
      in_data8 = 8'($urandom);
      #1;
      n_tests++;
      if (in_ready4 !== 1'b1) begin
        n_fail++;
        $display("FAIL indep_ready sel=%0d: got %b expected 1", in_sel, in_ready4);
      end
      tick();
      n_tests++;
      if (ov4[0] !== 1'b1 || od4[0] !== 4'h6 || od4[in_sel] !== mlast[in_sel][3:0]) begin
        n_fail++;
        $display("FAIL indep_hold: v0=%b d0=%h d%0d=%h expected 1/6/%h", ov4[0], od4[0], in_sel, od4[in_sel], mlast[in_sel][3:0]);
      end
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    for (int k = 0; k < 301; k++) begin
      in_data8 = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (c4[0] !== 8'd255 || c8[0] !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cnt0: got %0d/%0d expected 255", c4[0], c8[0]);
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (c4[i] !== mcnt[i][7:0]) begin
        n_fail++;
        $display("FAIL sat_other ch=%0d: got %0d expected %0d", i, c4[i], mcnt[i]);
      end
    end
  endtask

  task automatic test_random();
    bit exp_r;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 2'($urandom);
        in_data8 = 8'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      exp_r = (chq[in_sel].size() == 0) || out_ready[in_sel];
      n_tests++;
      if (in_ready4 !== exp_r || in_ready8 !== exp_r) begin
        n_fail++;
        $display("FAIL rnd_ready cyc=%0d: got %b/%b expected %b", cyc, in_ready4, in_ready8, exp_r);
      end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ov4[i] !== (chq[i].size() != 0) || ov8[i] !== (chq[i].size() != 0) ||
            od4[i] !== mlast[i][3:0] || od8[i] !== mlast[i] ||
            c4[i] !== mcnt[i][7:0] || c8[i] !== mcnt[i][7:0]) begin
          n_fail++;
          $display("FAIL rnd_ch cyc=%0d ch=%0d: v=%b/%b d=%h/%h cnt=%0d/%0d expected v=%b d=%h cnt=%0d",
                   cyc, i, ov4[i], ov8[i], od4[i], od8[i], c4[i], c8[i],
                   (chq[i].size() != 0), mlast[i], mcnt[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_throughput();
    test_independence();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
